// File: rtl/fp_align.sv
// Exponent-alignment stage of the single-precision adder: unpacks the ordered
// operand pair, then right-shifts the smaller significand with sticky capture.
module fp_align (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] OP_L,
  input  logic [31:0] OP_S,
  input  logic        meq,
  input  logic        eqn,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [7:0]  EXP,
  output logic [26:0] MANT_L,
  output logic [26:0] MANT_S,
  output logic        SIGN,
  output logic        SUB,
  output logic        ZERO,
  output logic        SPECIAL
);

  // Right shift by d with every dropped bit folded into bit 0.
  function automatic logic [26:0] align_sig(input logic [26:0] s, input logic [7:0] d);
    logic [26:0] shifted;
    logic [26:0] mask;
    if (d < 8'd27) begin
      shifted   = s >> d;
      mask      = ~(27'h7FF_FFFF << d);
      align_sig = {shifted[26:1], shifted[0] | (|(s & mask))};
    end else begin
      align_sig = {26'd0, |s};
    end
  endfunction

  logic        v1_r, v2_r;
  logic        load1_s, load2_s;
  logic [7:0]  el_s, es_s, el_eff_s, es_eff_s;
  logic        hl_s, hs_s, zero_s, special_s;

  logic [7:0]  exp1_r, d1_r;
  logic [23:0] sig_l1_r, sig_s1_r;
  logic        sign1_r, sub1_r, zero1_r, special1_r;

  logic [7:0]  exp2_s;
  logic [26:0] mant_l2_s, mant_s2_s;
  logic        sign2_s, sub2_s, zero2_s, special2_s;

  assign load2_s  = v1_r & (~v2_r | OUT_READY);
  assign IN_READY = ~v1_r | ~v2_r | OUT_READY;
  assign load1_s  = IN_VALID & IN_READY;

  assign el_s     = OP_L[30:23];
  assign es_s     = OP_S[30:23];
  assign hl_s     = |el_s;
  assign hs_s     = |es_s;
  assign el_eff_s = hl_s ? el_s : 8'd1;
  assign es_eff_s = hs_s ? es_s : 8'd1;
  assign special_s = (&el_s) | (&es_s);
  // Bit-identical operands share zero-ness, so meq short-cuts the OP_S test.
  assign zero_s    = eqn | ((OP_L[30:0] == 31'd0) & (meq | (OP_S[30:0] == 31'd0)));

  // Stage 1: unpack and register exponent difference and flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      v1_r       <= 1'b0;
      exp1_r     <= 8'd0;
      d1_r       <= 8'd0;
      sig_l1_r   <= 24'd0;
      sig_s1_r   <= 24'd0;
      sign1_r    <= 1'b0;
      sub1_r     <= 1'b0;
      zero1_r    <= 1'b0;
      special1_r <= 1'b0;
    end else begin
      if (load1_s) begin
        v1_r       <= 1'b1;
        exp1_r     <= el_eff_s;
        d1_r       <= el_eff_s - es_eff_s;
        sig_l1_r   <= {hl_s, OP_L[22:0]};
        sig_s1_r   <= {hs_s, OP_S[22:0]};
        sign1_r    <= OP_L[31];
        sub1_r     <= OP_L[31] ^ OP_S[31];
        zero1_r    <= zero_s;
        special1_r <= special_s;
      end else if (load2_s) begin
        v1_r <= 1'b0;
      end else begin
        v1_r <= v1_r;
      end
    end
  end

  // Stage 2 combinational: alignment and zero/special result shaping.
  always_comb begin
    exp2_s     = exp1_r;
    mant_l2_s  = {sig_l1_r, 3'b000};
    mant_s2_s  = align_sig({sig_s1_r, 3'b000}, d1_r);
    sign2_s    = sign1_r;
    sub2_s     = sub1_r;
    zero2_s    = 1'b0;
    special2_s = 1'b0;
    if (special1_r) begin
      exp2_s     = 8'd255;
      special2_s = 1'b1;
    end else if (zero1_r) begin
      exp2_s    = 8'd0;
      mant_l2_s = 27'd0;
      mant_s2_s = 27'd0;
      sign2_s   = 1'b0;
      sub2_s    = 1'b0;
      zero2_s   = 1'b1;
    end else begin
      zero2_s = 1'b0;
    end
  end

  // Stage 2: output slot, held while downstream stalls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      v2_r    <= 1'b0;
      EXP     <= 8'd0;
      MANT_L  <= 27'd0;
      MANT_S  <= 27'd0;
      SIGN    <= 1'b0;
      SUB     <= 1'b0;
      ZERO    <= 1'b0;
      SPECIAL <= 1'b0;
    end else begin
      if (load2_s) begin
        v2_r    <= 1'b1;
        EXP     <= exp2_s;
        MANT_L  <= mant_l2_s;
        MANT_S  <= mant_s2_s;
        SIGN    <= sign2_s;
        SUB     <= sub2_s;
        ZERO    <= zero2_s;
        SPECIAL <= special2_s;
      end else if (OUT_READY) begin
        v2_r <= 1'b0;
      end else begin
        v2_r <= v2_r;
      end
    end
  end

  assign OUT_VALID = v2_r;

endmodule

// File: tb/tb_fp_align.sv
// Directed bench for fp_align: vector table plus backpressure and reset-mid-stall sequences.
module tb_fp_align;
  logic        CLK = 1'b0;
  logic        RST, meq, eqn, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [31:0] OP_L, OP_S;
  logic [7:0]  EXP;
  logic [26:0] MANT_L, MANT_S;
  logic        SIGN, SUB, ZERO, SPECIAL;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fp_align dut (
    .CLK(CLK), .RST(RST), .OP_L(OP_L), .OP_S(OP_S), .meq(meq), .eqn(eqn),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .EXP(EXP), .MANT_L(MANT_L), .MANT_S(MANT_S), .SIGN(SIGN), .SUB(SUB),
    .ZERO(ZERO), .SPECIAL(SPECIAL)
  );

  typedef struct {
    logic [31:0] op_l, op_s;
    logic        meq, eqn;
    logic [7:0]  exp;
    logic [26:0] ml, ms;
    logic        sign, sub, zero, special;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vec_t v;
    int k, sent, got;
    logic [26:0] exp_ml[4];

    vecs[0]  = '{32'h08000004, 32'h01000010, 1'b0, 1'b0, 8'h10, 27'h4000020, 27'h0001001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h02000010, 32'h02000004, 1'b0, 1'b0, 8'h04, 27'h4000080, 27'h4000020, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'h02000010, 32'h82000010, 1'b0, 1'b1, 8'h00, 27'h0, 27'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{32'h4A000000, 32'h3F800000, 1'b0, 1'b0, 8'h94, 27'h4000000, 27'h0000020, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h4A000000, 32'h32000000, 1'b0, 1'b0, 8'h94, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h3F800000, 32'hBF000000, 1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h2000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{32'hC0000000, 32'h3F800000, 1'b0, 1'b0, 8'h80, 27'h4000000, 27'h2000000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{32'h00800000, 32'h00000001, 1'b0, 1'b0, 8'h01, 27'h4000000, 27'h0000008, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'h00000000, 32'h80000000, 1'b0, 1'b0, 8'h00, 27'h0, 27'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{32'h7F800000, 32'h3F800000, 1'b0, 1'b0, 8'hFF, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{32'h40400000, 32'h40400000, 1'b1, 1'b0, 8'h80, 27'h6000000, 27'h6000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h4C000000, 32'h3F800001, 1'b0, 1'b0, 8'h98, 27'h4000000, 27'h0000003, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'h4D000000, 32'h3F800000, 1'b0, 1'b0, 8'h9A, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0};

    RST = 1'b1; meq = 1'b0; eqn = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    OP_L = 32'd0; OP_S = 32'd0;
    step(); step();
    RST = 1'b0;
    #1;
    check("reset_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("reset_exp", {24'd0, EXP}, 32'd0);
    check("reset_mant_l", {5'd0, MANT_L}, 32'd0);
    check("reset_in_ready", {31'd0, IN_READY}, 32'd1);

    for (int i = 0; i < 13; i++) begin
      v = vecs[i];
      step();
      OP_L = v.op_l; OP_S = v.op_s; meq = v.meq; eqn = v.eqn;
      IN_VALID = 1'b1; OUT_READY = 1'b1;
      step();
      IN_VALID = 1'b0; meq = 1'b0; eqn = 1'b0;
      k = 1;
      while (!OUT_VALID && k < 6) begin
        step();
        k++;
      end
      check($sformatf("v%0d_latency", i), k, 32'd2);
      check($sformatf("v%0d_exp", i), {24'd0, EXP}, {24'd0, v.exp});
      check($sformatf("v%0d_mant_l", i), {5'd0, MANT_L}, {5'd0, v.ml});
      check($sformatf("v%0d_mant_s", i), {5'd0, MANT_S}, {5'd0, v.ms});
      check($sformatf("v%0d_flags", i), {28'd0, SIGN, SUB, ZERO, SPECIAL},
            {28'd0, v.sign, v.sub, v.zero, v.special});
    end
    step();

    // Backpressure: four words, output stalled for the first four cycles.
    for (int w = 0; w < 4; w++) exp_ml[w] = 27'h4000000 | (27'(w + 1) << 3);
    sent = 0; got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      step();
      OUT_READY = (c >= 4);
      IN_VALID  = (sent < 4);
      OP_L = 32'h3F800000 + 32'(sent + 1);
      OP_S = OP_L;
      #1;
      if (c == 2 || c == 3) begin
        check($sformatf("bp_in_ready_c%0d", c), {31'd0, IN_READY}, 32'd0);
        check($sformatf("bp_sent_c%0d", c), sent, 32'd2);
        check($sformatf("bp_hold_c%0d", c), {4'd0, OUT_VALID, MANT_L}, {4'd0, 1'b1, exp_ml[0]});
      end
      if (OUT_VALID && OUT_READY) begin
        check($sformatf("bp_order_%0d", got), {5'd0, MANT_L}, {5'd0, exp_ml[got]});
        got++;
      end
      if (IN_VALID && IN_READY) sent++;
    end
    check("bp_all_out", got, 32'd4);
    IN_VALID = 1'b0;
    step();
    check("bp_no_dup", {31'd0, OUT_VALID}, 32'd0);

    // Reset while two words are held.
    OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    OP_L = 32'h08000004; OP_S = 32'h01000010;
    step();
    step();
    IN_VALID = 1'b0;
    #1;
    check("stall_full", {30'd0, OUT_VALID, IN_READY}, {30'd0, 1'b1, 1'b0});
    RST = 1'b1;
    step();
    RST = 1'b0;
    OUT_READY = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_outputs", {5'd0, MANT_L} | {5'd0, MANT_S} | {24'd0, EXP}, 32'd0);
    check("rst_in_ready", {31'd0, IN_READY}, 32'd1);
    k = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (OUT_VALID) k++;
    end
    check("rst_no_stale", k, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
